// File: rtl/ysyx_22041211_defs.sv
// ---------------------------------------------------------------------------
// ysyx_22041211_defs
// Shared definitions for the fetch sequencer slice:
//   - S_REQ / S_WAIT / S_HOLD : fetch FSM state encodings
//   - RESET_VEC_DEFAULT       : architectural PC after reset
//   - redirect_cause_t        : which redirect source won arbitration
//   - cause_is_redirect()     : true for any real redirect cause
// ---------------------------------------------------------------------------
package ysyx_22041211_defs;

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_TRAP = 2'd1,
        CAUSE_MRET = 2'd2,
        CAUSE_JUMP = 2'd3
    } redirect_cause_t;

    function automatic logic cause_is_redirect(input redirect_cause_t c);
        return c != CAUSE_NONE;
    endfunction

endpackage

// File: rtl/ysyx_22041211_redirect_arb.sv
// ---------------------------------------------------------------------------
// ysyx_22041211_redirect_arb
// Combinational 3-way redirect priority select: trap > mret > jump.
// Ports:
//   trap_valid/trap_target  CSR trap redirect (mtvec)
//   mret_valid/mret_target  CSR mret redirect (mepc)
//   jump_valid/jump_target  EXU branch/jump redirect
//   sel_valid               some redirect requested this cycle
//   sel_target              target of the winning source
//   sel_cause               which source won
// ---------------------------------------------------------------------------
module ysyx_22041211_redirect_arb
    import ysyx_22041211_defs::*;
#(
    parameter int unsigned DATA_LEN = 32
) (
    input  logic                trap_valid,
    input  logic [DATA_LEN-1:0] trap_target,
    input  logic                mret_valid,
    input  logic [DATA_LEN-1:0] mret_target,
    input  logic                jump_valid,
    input  logic [DATA_LEN-1:0] jump_target,
    output logic                sel_valid,
    output logic [DATA_LEN-1:0] sel_target,
    output redirect_cause_t     sel_cause
);

    always_comb begin
        sel_valid  = 1'b0;
        sel_target = '0;
        sel_cause  = CAUSE_NONE;
        if (trap_valid) begin
            sel_valid  = 1'b1;
            sel_target = trap_target;
            sel_cause  = CAUSE_TRAP;
        end else if (mret_valid) begin
            sel_valid  = 1'b1;
            sel_target = mret_target;
            sel_cause  = CAUSE_MRET;
        end else if (jump_valid) begin
            sel_valid  = 1'b1;
            sel_target = jump_target;
            sel_cause  = CAUSE_JUMP;
        end
    end

endmodule

// File: rtl/ysyx_22041211_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22041211_fetch_ctrl
// Fetch sequencer: owns the PC, issues IMEM requests, hands instructions to
// decode and applies trap/mret/jump redirects.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/addr/ready     IMEM request channel (addr = pc)
//   rsp_valid/data/ready     IMEM response channel
//   inst_valid/inst/inst_pc  instruction to decode, inst_ready accepts it
//   jump/mret/trap_valid     redirect pulses with their targets
//   misalign_err             misaligned-target pulse (YSYX_22041211_MISALIGN_CHECK_EN only)
// Configuration macro: YSYX_22041211_MISALIGN_CHECK_EN
//   defined   : misaligned winning targets are dropped and flagged
//   undefined : target[1:0] is cleared and the redirect applied
// ---------------------------------------------------------------------------
module ysyx_22041211_fetch_ctrl
    import ysyx_22041211_defs::*;
#(
    parameter int unsigned          DATA_LEN  = 32,
    parameter logic [DATA_LEN-1:0]  RESET_VEC = DATA_LEN'(RESET_VEC_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                req_valid,
    output logic [DATA_LEN-1:0] req_addr,
    input  logic                req_ready,
    input  logic                rsp_valid,
    input  logic [DATA_LEN-1:0] rsp_data,
    output logic                rsp_ready,
    output logic                inst_valid,
    output logic [DATA_LEN-1:0] inst,
    output logic [DATA_LEN-1:0] inst_pc,
    input  logic                inst_ready,
    input  logic                jump_valid,
    input  logic [DATA_LEN-1:0] jump_target,
    input  logic                mret_valid,
    input  logic [DATA_LEN-1:0] mret_target,
    input  logic                trap_valid,
    input  logic [DATA_LEN-1:0] trap_target
`ifdef YSYX_22041211_MISALIGN_CHECK_EN
    ,
    output logic                misalign_err
`endif
);

    logic [1:0]          state, state_n;
    logic [DATA_LEN-1:0] pc, pc_n;
    logic                pending, pending_n;
    logic [DATA_LEN-1:0] pending_pc, pending_pc_n;
    logic                latch_inst;

    logic                sel_valid;
    logic [DATA_LEN-1:0] sel_target;
    redirect_cause_t     sel_cause;
    logic                redir_req;

    // Redirect after alignment policy: tgt_valid/tgt_pc is what the FSM acts on.
    logic                tgt_valid;
    logic [DATA_LEN-1:0] tgt_pc;

    // A redirect either arriving now or parked earlier; the fresh one wins.
    logic                redir_hit;
    logic [DATA_LEN-1:0] redir_pc;

    ysyx_22041211_redirect_arb #(
        .DATA_LEN (DATA_LEN)
    ) u_arb (
        .trap_valid  (trap_valid),
        .trap_target (trap_target),
        .mret_valid  (mret_valid),
        .mret_target (mret_target),
        .jump_valid  (jump_valid),
        .jump_target (jump_target),
        .sel_valid   (sel_valid),
        .sel_target  (sel_target),
        .sel_cause   (sel_cause)
    );

    assign redir_req = sel_valid && cause_is_redirect(sel_cause);

`ifdef YSYX_22041211_MISALIGN_CHECK_EN
    logic tgt_aligned;
    assign tgt_aligned = (sel_target[1:0] == 2'b00);
    assign tgt_valid   = redir_req && tgt_aligned;
    assign tgt_pc      = sel_target;

    always_ff @(posedge clk) begin
        if (rst) misalign_err <= 1'b0;
        else     misalign_err <= redir_req && !tgt_aligned;
    end
`else
    assign tgt_valid = redir_req;
    assign tgt_pc    = sel_target & ~DATA_LEN'(3);
`endif

    assign redir_hit = tgt_valid || pending;
    assign redir_pc  = tgt_valid ? tgt_pc : pending_pc;
    assign req_addr  = pc;

    // A redirect seen before the response lands is parked in pending; the
    // in-flight fetch still completes and its response is thrown away.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        pending_n    = pending;
        pending_pc_n = pending_pc;
        latch_inst   = 1'b0;
        case (state)
            S_REQ: begin
                if (tgt_valid) begin
                    pending_n    = 1'b1;
                    pending_pc_n = tgt_pc;
                end
                if (req_valid && req_ready) state_n = S_WAIT;
            end
            S_WAIT: begin
                if (rsp_valid && rsp_ready) begin
                    if (redir_hit) begin
                        pc_n      = redir_pc;
                        pending_n = 1'b0;
                        state_n   = S_REQ;
                    end else begin
                        latch_inst = 1'b1;
                        state_n    = S_HOLD;
                    end
                end else if (tgt_valid) begin
                    pending_n    = 1'b1;
                    pending_pc_n = tgt_pc;
                end
            end
            S_HOLD: begin
                if (redir_hit) begin
                    pc_n      = redir_pc;
                    pending_n = 1'b0;
                    state_n   = S_REQ;
                end else if (inst_ready) begin
                    pc_n    = pc + DATA_LEN'(4);
                    state_n = S_REQ;
                end
            end
            default: state_n = S_REQ;
        endcase
    end

    // Handshake outputs are registered from the next state so none of them
    // has a combinational path from the redirect inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_VEC;
            pending    <= 1'b0;
            pending_pc <= '0;
            req_valid  <= 1'b0;
            rsp_ready  <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            pending    <= pending_n;
            pending_pc <= pending_pc_n;
            req_valid  <= (state_n == S_REQ);
            rsp_ready  <= (state_n == S_WAIT);
            inst_valid <= (state_n == S_HOLD);
            if (latch_inst) begin
                inst    <= rsp_data;
                inst_pc <= pc;
            end
        end
    end

endmodule
